// File: rtl/aes_key_expansion_if.sv
// rtl/aes_key_expansion_if.sv - start/result handshake bundle for the AES-128 key schedule
interface aes_key_expansion_if;
    logic         valid_i;
    logic [127:0] key_i;
    logic         valid_o;
    logic [127:0] round_key_o [11];

    modport master (
        output valid_i,
        output key_i,
        input  valid_o,
        input  round_key_o
    );

    modport slave (
        input  valid_i,
        input  key_i,
        output valid_o,
        output round_key_o
    );
endinterface

// File: rtl/aes_key_expansion.sv
// rtl/aes_key_expansion.sv - iterative AES-128 key schedule, one round key per clock
module aes_key_expansion (
    input  logic               clk,
    input  logic               rst_n,
    aes_key_expansion_if.slave bus
);
    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state;
    logic [3:0]   rnd;
    logic         valid_q;
    logic [127:0] rk [11];
    // Copy of the most recently produced round key, so the round function never needs a variable read index.
    logic [127:0] cur;

    logic [31:0]  t, n0, n1, n2, n3;
    logic [127:0] next_key;

    always_comb begin
        t        = sub_word({cur[23:0], cur[31:24]}) ^ {rcon(rnd), 24'h0};
        n0       = cur[127:96] ^ t;
        n1       = cur[95:64]  ^ n0;
        n2       = cur[63:32]  ^ n1;
        n3       = cur[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rnd     <= 4'd0;
            valid_q <= 1'b0;
            cur     <= '0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        rk[0] <= bus.key_i;
                        cur   <= bus.key_i;
                        rnd   <= 4'd1;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk[rnd] <= next_key;
                    cur     <= next_key;
                    if (rnd == 4'd10) begin
                        valid_q <= 1'b1;
                        rnd     <= 4'd0;
                        state   <= IDLE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.round_key_o = rk;
endmodule

// File: tb/tb_aes_key_expansion.sv
// tb/tb_aes_key_expansion.sv - scoreboard bench with a word-level FIPS-197 key schedule model
module tb_aes_key_expansion;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_key_expansion_if bus ();
    aes_key_expansion dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [1407:0] keys;
        logic [31:0]   cyc;
    } exp_t;

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    logic        prev_v = 1'b0;
    logic [7:0]  sbox_m [256];
    logic [7:0]  rcon_m [11];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_tables();
        logic [7:0] inv, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        r = 8'h01;
        rcon_m[0] = 8'h00;
        for (int i = 1; i < 11; i++) begin
            rcon_m[i] = r;
            r = gmul(r, 8'h02);
        end
    endtask

    function automatic logic [1407:0] model(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   tmp;
        logic [1407:0] flat;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
                tmp = tmp ^ {rcon_m[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            flat[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return flat;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.valid_o && prev_v) begin
                checks++; errors++;
                $display("FAIL pulse_width valid_o high on consecutive cycles");
            end else if (bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid valid_o=1 with no request pending");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL latency cycle %0d required %0d", cyc, e.cyc);
                    end
                    for (int r = 0; r < 11; r++) begin
                        checks++;
                        if (bus.round_key_o[r] !== e.keys[r*128 +: 128]) begin
                            errors++;
                            $display("FAIL rk[%0d] got %h required %h", r, bus.round_key_o[r], e.keys[r*128 +: 128]);
                        end
                    end
                end
            end
        end
        prev_v <= (rst_n === 1'b1) ? bus.valid_o : 1'b0;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic issue(input logic [127:0] k);
        exp_t e;
        bus.valid_i = 1'b1;
        bus.key_i   = k;
        e.keys = model(k);
        e.cyc  = cyc + 32'd11;
        exp_q.push_back(e);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.valid_o) begin
            errors++;
            $display("FAIL timeout valid_o=0 after %0d cycles required 1", n);
        end
    endtask

    task automatic check_cleared();
        check("reset_valid_o", {127'h0, bus.valid_o}, 128'h0);
        for (int r = 0; r < 11; r++) check($sformatf("reset_rk%0d", r), bus.round_key_o[r], 128'h0);
    endtask

    initial begin
        logic [127:0] ka, kb;
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.key_i   = '0;
        build_tables();
        repeat (3) @(negedge clk);
        check_cleared();
        rst_n = 1'b1;
        @(negedge clk);

        issue(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_valid();
        check("fips_rk0", bus.round_key_o[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("fips_rk1", bus.round_key_o[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_rk10", bus.round_key_o[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        repeat (2) @(negedge clk);

        issue(128'h0);
        wait_valid();
        check("zero_rk1", bus.round_key_o[1], 128'h62636363626363636263636362636363);
        check("zero_rk10", bus.round_key_o[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        @(negedge clk);

        issue({128{1'b1}});
        wait_valid();
        check("ones_rk1", bus.round_key_o[1], 128'he8e9e9e917161616e8e9e9e917161616);
        @(negedge clk);

        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        issue(ka);
        wait_valid();
        issue(kb);
        wait_valid();
        @(negedge clk);

        issue(ka);
        repeat (3) @(negedge clk);
        bus.valid_i = 1'b1;
        bus.key_i   = kb;
        @(negedge clk);
        bus.valid_i = 1'b0;
        wait_valid();
        repeat (15) @(negedge clk);

        issue(kb);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_cleared();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(ka);
        wait_valid();
        @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            issue({$urandom, $urandom, $urandom, $urandom});
            wait_valid();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (15) @(negedge clk);
        check("pending_empty", 128'(exp_q.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
